tx_fifo: RTL and testbench

TX_FIFO -- requirements
Module: tx_fifo

---
 rtl/uart_pkg.sv | 11 +
 rtl/tx_fifo_mem.sv | 31 +++
 rtl/tx_fifo.sv | 114 +++++++++++
 tb/tb_tx_fifo.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared defaults for the UART transmit path: data width, FIFO depth and
// the occupancy-counter width helper.
package uart_pkg;
  localparam int BITWIDTH   = 8;
  localparam int FIFO_DEPTH = 16;

  // One extra bit so the counter can represent a completely full FIFO.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/tx_fifo_mem.sv
// DEPTH x WIDTH storage with one write port and one registered read port.
// Only the read register is reset; the array itself is never cleared.
module tx_fifo_mem #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read-before-write: a same-address write/read returns the old word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/tx_fifo.sv
// Transmit FIFO: pointer, occupancy and status/error-flag control around a
// single tx_fifo_mem storage block.
module tx_fifo
  import uart_pkg::*;
#(
  parameter  int WIDTH     = BITWIDTH,
  parameter  int DEPTH     = FIFO_DEPTH,
  parameter  int AFULL_TH  = DEPTH - 2,
  parameter  int AEMPTY_TH = 2,
  localparam int CW        = cnt_w(DEPTH)
) (
  input  logic             tClk,
  input  logic             tRst,
  input  logic             tWR,
  input  logic [WIDTH-1:0] tdataIn,
  input  logic             tRD,
  output logic [WIDTH-1:0] tdataOut,
  output logic             tVALID,
  output logic             tEMPTY,
  output logic             tFULL,
  output logic             ttxrdy,
  output logic             tAFULL,
  output logic             tAEMPTY,
  output logic [CW-1:0]    tCount,
  output logic             tOVF,
  output logic             tUDF,
  input  logic             tClrErr
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          vld_q, vld_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc;
  logic          empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // A read frees a slot on the same edge, so a full FIFO may still take a write.
  assign wr_acc = tWR && (!full || tRD);
  assign rd_acc = tRD && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = rd_acc;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);

    // A new error in the clear cycle keeps the flag set.
    if (tClrErr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (tWR && full && !tRD) ovf_d = 1'b1;
    if (tRD && empty)        udf_d = 1'b1;
  end

  always_ff @(posedge tClk or negedge tRst) begin
    if (!tRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  tx_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (tClk),
    .rst_ni  (tRst),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (tdataIn),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (tdataOut)
  );

  assign tVALID  = vld_q;
  assign tEMPTY  = empty;
  assign tFULL   = full;
  assign ttxrdy  = !full;
  assign tAFULL  = (count_q >= AFULL_C);
  assign tAEMPTY = (count_q <= AEMPTY_C);
  assign tCount  = count_q;
  assign tOVF    = ovf_q;
  assign tUDF    = udf_q;
endmodule

// File: tb/tb_tx_fifo.sv
// Directed bench for tx_fifo (WIDTH=8, DEPTH=16) with a read-data scoreboard.
module tb_tx_fifo;
  logic       tClk = 1'b0;
  logic       tRst = 1'b0;
  logic       tWR = 1'b0;
  logic [7:0] tdataIn = '0;
  logic       tRD = 1'b0;
  logic       tClrErr = 1'b0;
  logic [7:0] tdataOut;
  logic       tVALID, tEMPTY, tFULL, ttxrdy, tAFULL, tAEMPTY, tOVF, tUDF;
  logic [4:0] tCount;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_d;

  tx_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .tClk(tClk), .tRst(tRst), .tWR(tWR), .tdataIn(tdataIn), .tRD(tRD),
    .tdataOut(tdataOut), .tVALID(tVALID), .tEMPTY(tEMPTY), .tFULL(tFULL),
    .ttxrdy(ttxrdy), .tAFULL(tAFULL), .tAEMPTY(tAEMPTY), .tCount(tCount),
    .tOVF(tOVF), .tUDF(tUDF), .tClrErr(tClrErr)
  );

  always #5 tClk = ~tClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    tWR = wr; tdataIn = d; tRD = rd; tClrErr = clr;
    @(posedge tClk);
    #1;
    tWR = 1'b0; tRD = 1'b0; tClrErr = 1'b0;
  endtask

  // Monitor: every valid read word must match the oldest expected word.
  always @(negedge tClk) begin
    if (tRst && tVALID) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got %0h expected no read at %0t", tdataOut, $time);
      end else begin
        exp_d = exp_q.pop_front();
        chk("rd_data", 32'(tdataOut), 32'(exp_d));
      end
    end
  end

  initial begin
    // Reset state
    #3;
    chk("rst_count", 32'(tCount), 0);
    chk("rst_empty", 32'(tEMPTY), 1);
    chk("rst_full", 32'(tFULL), 0);
    chk("rst_txrdy", 32'(ttxrdy), 1);
    chk("rst_aempty", 32'(tAEMPTY), 1);
    chk("rst_afull", 32'(tAFULL), 0);
    chk("rst_valid", 32'(tVALID), 0);
    chk("rst_dout", 32'(tdataOut), 0);
    chk("rst_ovf", 32'(tOVF), 0);
    chk("rst_udf", 32'(tUDF), 0);
    @(negedge tClk);
    @(negedge tClk);
    tRst = 1'b1;

    // Fill with 0x01..0x10
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i + 1), 1'b0, 1'b0);
      chk("fill_count", 32'(tCount), 32'(i + 1));
      chk("fill_afull", 32'(tAFULL), 32'((i + 1) >= 14));
      chk("fill_aempty", 32'(tAEMPTY), 32'((i + 1) <= 2));
    end
    chk("full_flag", 32'(tFULL), 1);
    chk("full_txrdy", 32'(ttxrdy), 0);
    chk("full_empty", 32'(tEMPTY), 0);

    // Write while full: dropped, overflow sticky
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    chk("ovf_set", 32'(tOVF), 1);
    chk("ovf_count", 32'(tCount), 16);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_sticky", 32'(tOVF), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(tOVF), 0);

    // Simultaneous write/read while full
    exp_q.push_back(8'h01);
    cyc(1'b1, 8'h11, 1'b1, 1'b0);
    chk("wr_rd_full_count", 32'(tCount), 16);
    chk("wr_rd_full_ovf", 32'(tOVF), 0);
    chk("wr_rd_full_valid", 32'(tVALID), 1);

    // Drain: 0x02..0x10 then 0x11
    for (int i = 2; i <= 17; i++) begin
      exp_q.push_back(8'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_count", 32'(tCount), 0);
    chk("drain_empty", 32'(tEMPTY), 1);
    chk("drain_ovf", 32'(tOVF), 0);

    // Read while empty
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set", 32'(tUDF), 1);
    chk("udf_valid", 32'(tVALID), 0);
    chk("udf_dout_hold", 32'(tdataOut), 32'h11);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_clr", 32'(tUDF), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("udf_clr_vs_new", 32'(tUDF), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_clr2", 32'(tUDF), 0);

    // Simultaneous write/read while empty: write lands, read ignored
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("wr_rd_empty_count", 32'(tCount), 1);
    chk("wr_rd_empty_udf", 32'(tUDF), 1);
    chk("wr_rd_empty_valid", 32'(tVALID), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // 40 interleaved pairs at occupancy 1: pointers wrap twice
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back((i == 0) ? 8'h77 : 8'(32'h20 + i - 1));
      cyc(1'b1, 8'(32'h20 + i), 1'b1, 1'b0);
      chk("pair_count", 32'(tCount), 1);
    end
    exp_q.push_back(8'h47);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pair_end_count", 32'(tCount), 0);
    chk("pair_flags", 32'({tOVF, tUDF}), 0);

    // Asynchronous reset at count 7, between edges
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(32'hC0 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(tCount), 7);
    #2;
    tRst = 1'b0;
    #1;
    chk("arst_count", 32'(tCount), 0);
    chk("arst_empty", 32'(tEMPTY), 1);
    chk("arst_txrdy", 32'(ttxrdy), 1);
    chk("arst_aempty", 32'(tAEMPTY), 1);
    chk("arst_afull", 32'(tAFULL), 0);
    chk("arst_valid", 32'(tVALID), 0);
    chk("arst_dout", 32'(tdataOut), 0);
    #3;
    tRst = 1'b1;

    // First write after reset is accepted; old contents not visible
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("post_rst_count", 32'(tCount), 1);
    exp_q.push_back(8'h5A);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_empty", 32'(tEMPTY), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
